// File: rtl/burst_mem_slave.sv
// Burst memory slave: one write/read burst at a time; first read beat 1 cycle after accept, beats back-to-back under rdata_ready.
// Write beats stall on wdata_valid, read beats hold under !rdata_ready. `BURST_SLAVE_BOUNDARY_CHK_EN rejects bursts crossing the top of memory.
module burst_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic              io_cmd_wr,
    input  logic [ADDR_W-1:0] io_cmd_addr,
    input  logic [LEN_W-1:0]  io_cmd_len,
    input  logic              io_wdata_valid,
    output logic              io_wdata_ready,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_rdata_valid,
    input  logic              io_rdata_ready,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rdata_last,
    output logic              io_done,
    output logic              io_err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvld_q, rvld_d;
    logic               rlast_q, rlast_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  mem [2**ADDR_W];
    logic               mem_we;
    logic [ADDR_W-1:0]  ptr_inc;
    logic               cmd_bad;

    assign ptr_inc = ptr_q + 1'b1;

`ifdef BURST_SLAVE_BOUNDARY_CHK_EN
    logic [ADDR_W:0] cmd_end;
    assign cmd_end = {1'b0, io_cmd_addr} + (ADDR_W+1)'(io_cmd_len);
    assign cmd_bad = (io_cmd_len == '0) || (cmd_end > (ADDR_W+1)'(2**ADDR_W));
`else
    assign cmd_bad = (io_cmd_len == '0);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rvld_d  = rvld_q;
        rlast_d = rlast_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_d = io_cmd_addr;
                        cnt_d = io_cmd_len;
                        if (io_cmd_wr) begin
                            state_d = WRITE;
                        end else begin
                            // first beat is fetched during accept so it is valid next cycle
                            state_d = READ;
                            rdata_d = mem[io_cmd_addr];
                            rvld_d  = 1'b1;
                            rlast_d = (io_cmd_len == LEN_W'(1));
                        end
                    end
                end
            end
            WRITE: begin
                if (io_wdata_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_inc;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            READ: begin
                // ptr_q addresses the beat currently on io_rdata
                if (io_rdata_ready) begin
                    cnt_d = cnt_q - 1'b1;
                    ptr_d = ptr_inc;
                    if (cnt_q == LEN_W'(1)) begin
                        rvld_d  = 1'b0;
                        rlast_d = 1'b0;
                        state_d = RESP;
                    end else begin
                        rdata_d = mem[ptr_inc];
                        rlast_d = (cnt_q == LEN_W'(2));
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            rlast_q <= rlast_d;
            err_q   <= err_d;
        end
    end

    // storage is deliberately not reset so an aborted burst keeps its written beats
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[ptr_q] <= io_wdata;
        end
    end

    assign io_cmd_ready   = (state_q == IDLE);
    assign io_wdata_ready = (state_q == WRITE);
    assign io_rdata_valid = rvld_q;
    assign io_rdata       = rdata_q;
    assign io_rdata_last  = rlast_q;
    assign io_done        = (state_q == RESP);
    assign io_err         = err_q;

endmodule

// File: tb/tb_burst_mem_slave.sv
// Randomized bench for burst_mem_slave against an array-based memory model.
module tb_burst_mem_slave;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_cmd_valid, io_cmd_ready, io_cmd_wr;
    logic [AW-1:0] io_cmd_addr;
    logic [LW-1:0] io_cmd_len;
    logic          io_wdata_valid, io_wdata_ready;
    logic [DW-1:0] io_wdata;
    logic          io_rdata_valid, io_rdata_ready, io_rdata_last;
    logic [DW-1:0] io_rdata;
    logic          io_done, io_err;

    burst_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset),
        .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready), .io_cmd_wr(io_cmd_wr),
        .io_cmd_addr(io_cmd_addr), .io_cmd_len(io_cmd_len),
        .io_wdata_valid(io_wdata_valid), .io_wdata_ready(io_wdata_ready), .io_wdata(io_wdata),
        .io_rdata_valid(io_rdata_valid), .io_rdata_ready(io_rdata_ready), .io_rdata(io_rdata),
        .io_rdata_last(io_rdata_last), .io_done(io_done), .io_err(io_err)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] wq [$];
    bit          wv_pat [$];
    bit          rr_pat [$];
    int          wgap_pct = 0;
    int          rstall_pct = 0;
    logic [31:0] got_d [$];
    bit          got_l [$];
    int          drv_viol;
    bit          drv_done_ok;
    bit          drv_first_ok;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input bit wr, input int addr, input int len, output bit ok);
        int guard = 0;
        io_cmd_valid = 1'b1;
        io_cmd_wr    = wr;
        io_cmd_addr  = AW'(addr);
        io_cmd_len   = LW'(len);
        while (io_cmd_ready !== 1'b1 && guard < 50) begin
            cyc();
            guard++;
        end
        ok = (io_cmd_ready === 1'b1);
        cyc();
        io_cmd_valid = 1'b0;
    endtask

    // Drives the beats in wq, updating the model as each beat is offered with valid.
    task automatic do_write(input int addr, input int len);
        bit ok;
        bit v;
        int i = 0;
        int guard = 0;
        drv_viol = 0;
        send_cmd(1'b1, addr, len, ok);
        if (!ok) drv_viol++;
        while (i < len && guard < 500) begin
            if (wv_pat.size() > 0) v = wv_pat.pop_front();
            else v = ($urandom_range(99) >= wgap_pct);
            if (io_wdata_ready !== 1'b1 || io_done !== 1'b0 || io_cmd_ready !== 1'b0) drv_viol++;
            io_wdata_valid = v;
            io_wdata = v ? wq[i] : $urandom;
            if (v) begin
                mdl[(addr + i) % DEPTH] = wq[i];
                i++;
            end
            cyc();
            guard++;
        end
        if (i < len) drv_viol++;
        io_wdata_valid = 1'b0;
        drv_done_ok = (io_done === 1'b1) && (io_cmd_ready === 1'b0) && (io_wdata_ready === 1'b0);
        cyc();
        if (io_done !== 1'b0 || io_cmd_ready !== 1'b1) drv_done_ok = 1'b0;
        wq.delete();
    endtask

    // Collects accepted beats into got_d/got_l; counts bubbles and unstable held beats.
    task automatic do_read(input int addr, input int len);
        bit ok;
        bit r;
        bit held = 1'b0;
        logic [31:0] hd;
        logic hl;
        int n = 0;
        int guard = 0;
        drv_viol = 0;
        got_d.delete();
        got_l.delete();
        io_rdata_ready = 1'b0;
        send_cmd(1'b0, addr, len, ok);
        if (!ok) drv_viol++;
        drv_first_ok = (io_rdata_valid === 1'b1);
        while (n < len && guard < 500) begin
            if (rr_pat.size() > 0) r = rr_pat.pop_front();
            else r = ($urandom_range(99) >= rstall_pct);
            if (held && (io_rdata !== hd || io_rdata_last !== hl)) drv_viol++;
            if (io_rdata_valid !== 1'b1 || io_done !== 1'b0) drv_viol++;
            io_rdata_ready = r;
            held = !r;
            hd = io_rdata;
            hl = io_rdata_last;
            if (r && io_rdata_valid === 1'b1) begin
                got_d.push_back(io_rdata);
                got_l.push_back(io_rdata_last);
                n++;
            end
            cyc();
            guard++;
        end
        if (n < len) drv_viol++;
        io_rdata_ready = 1'b0;
        drv_done_ok = (io_done === 1'b1) && (io_rdata_valid === 1'b0) && (io_rdata_last === 1'b0);
        cyc();
        if (io_done !== 1'b0 || io_cmd_ready !== 1'b1) drv_done_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_cmd_valid = 0; io_cmd_wr = 0; io_cmd_addr = 0; io_cmd_len = 0;
        io_wdata_valid = 0; io_wdata = 0; io_rdata_ready = 0;
        repeat (3) cyc();
        n_checks++;
        if ({io_cmd_ready, io_wdata_ready, io_rdata_valid, io_rdata_last, io_done, io_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 100000",
                     {io_cmd_ready, io_wdata_ready, io_rdata_valid, io_rdata_last, io_done, io_err});
        end
        n_checks++;
        if (io_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, want 0", io_rdata);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 15; i++) wq.push_back($urandom);
        do_write(0, 15);
        n_checks++;
        if (drv_viol != 0 || !drv_done_ok) begin
            n_fail++;
            $display("FAIL fill_0_15: viol %0d done_ok %b, want 0 1", drv_viol, drv_done_ok);
        end
        wq.push_back($urandom);
        do_write(15, 1);
        n_checks++;
        if (drv_viol != 0 || !drv_done_ok) begin
            n_fail++;
            $display("FAIL fill_15_1: viol %0d done_ok %b, want 0 1", drv_viol, drv_done_ok);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) wq.push_back($urandom);
        wgap_pct = 0;
        rstall_pct = 0;
        do_write(6, 4);
        n_checks++;
        if (drv_viol != 0 || !drv_done_ok) begin
            n_fail++;
            $display("FAIL wr_burst: viol %0d done_ok %b, want 0 1", drv_viol, drv_done_ok);
        end
        do_read(6, 4);
        n_checks++;
        if (drv_viol != 0 || !drv_done_ok || !drv_first_ok) begin
            n_fail++;
            $display("FAIL rd_burst: viol %0d done_ok %b first_ok %b, want 0 1 1", drv_viol, drv_done_ok, drv_first_ok);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_d[i] !== mdl[6 + i] || got_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL rd_beat%0d: got %h last %b, want %h last %b", i, got_d[i], got_l[i], mdl[6 + i], i == 3);
            end
        end
    endtask

    task automatic test_backpressure();
        rr_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_read(6, 4);
        n_checks++;
        if (drv_viol != 0 || !drv_done_ok || got_d.size() != 4) begin
            n_fail++;
            $display("FAIL bp_protocol: viol %0d done_ok %b beats %0d, want 0 1 4", drv_viol, drv_done_ok, got_d.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_d[i] !== mdl[6 + i] || got_l[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h last %b, want %h last %b", i, got_d[i], got_l[i], mdl[6 + i], i == 3);
            end
        end
    endtask

    task automatic test_write_gaps();
        wv_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        wq = '{32'd1, 32'd2, 32'd3};
        do_write(2, 3);
        n_checks++;
        if (drv_viol != 0 || !drv_done_ok) begin
            n_fail++;
            $display("FAIL gap_burst: viol %0d done_ok %b, want 0 1", drv_viol, drv_done_ok);
        end
        do_read(1, 5);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got_d[i] !== mdl[1 + i]) begin
                n_fail++;
                $display("FAIL gap_mem%0d: got %h, want %h", 1 + i, got_d[i], mdl[1 + i]);
            end
        end
        n_checks++;
        if (got_d[1] !== 32'd1 || got_d[3] !== 32'd3) begin
            n_fail++;
            $display("FAIL gap_const: got %h %h, want 1 3", got_d[1], got_d[3]);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int dn = 0;
`ifdef BURST_SLAVE_BOUNDARY_CHK_EN
        send_cmd(1'b1, 14, 4, ok);
        n_checks++;
        if (!ok || io_err !== 1'b1 || io_cmd_ready !== 1'b1 || io_wdata_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_reject: err %b ready %b wready %b, want 1 1 0", io_err, io_cmd_ready, io_wdata_ready);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (io_done !== 1'b0 || io_err !== 1'b0) dn++;
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL wrap_quiet: got %0d stray done/err cycles, want 0", dn);
        end
        do_read(14, 2);
        n_checks++;
        if (got_d[0] !== mdl[14] || got_d[1] !== mdl[15]) begin
            n_fail++;
            $display("FAIL wrap_untouched: got %h %h, want %h %h", got_d[0], got_d[1], mdl[14], mdl[15]);
        end
`else
        wq = '{32'd5, 32'd6, 32'd7, 32'd8};
        do_write(14, 4);
        ok = drv_done_ok;
        do_read(14, 4);
        n_checks++;
        if (!ok || got_d.size() != 4 || got_d[0] !== 32'd5 || got_d[1] !== 32'd6 ||
            got_d[2] !== 32'd7 || got_d[3] !== 32'd8) begin
            n_fail++;
            $display("FAIL wrap_data: got %h %h %h %h done_ok %b, want 5 6 7 8 1",
                     got_d[0], got_d[1], got_d[2], got_d[3], ok);
        end
        do_read(0, 2);
        n_checks++;
        if (got_d[0] !== 32'd7 || got_d[1] !== 32'd8 || got_l[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_low: got %h %h last %b, want 7 8 1", got_d[0], got_d[1], got_l[1]);
        end
`endif
    endtask

    task automatic test_illegal();
        bit ok;
        send_cmd(1'b1, 5, 0, ok);
        n_checks++;
        if (!ok || io_err !== 1'b1 || io_cmd_ready !== 1'b1 || io_wdata_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_err: err %b ready %b wready %b, want 1 1 0", io_err, io_cmd_ready, io_wdata_ready);
        end
        cyc();
        n_checks++;
        if (io_err !== 1'b0 || io_done !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_pulse: err %b done %b, want 0 0", io_err, io_done);
        end
        do_read(5, 1);
        n_checks++;
        if (got_d[0] !== mdl[5] || got_l[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_mem: got %h last %b, want %h 1", got_d[0], got_l[0], mdl[5]);
        end
    endtask

    task automatic test_busy();
        int busy_bad = 0;
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        io_cmd_valid = 1'b1; io_cmd_wr = 1'b1; io_cmd_addr = 4'd3; io_cmd_len = 4'd2;
        cyc();
        io_cmd_wr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (io_cmd_ready !== 1'b0) busy_bad++;
            io_wdata_valid = 1'b1;
            io_wdata = (i == 0) ? a : b;
            cyc();
        end
        io_wdata_valid = 1'b0;
        mdl[3] = a;
        mdl[4] = b;
        if (io_cmd_ready !== 1'b0 || io_done !== 1'b1 || io_err !== 1'b0) busy_bad++;
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL busy_ready: got %0d busy cycles with ready/done wrong, want 0", busy_bad);
        end
        cyc();
        n_checks++;
        if (io_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_idle: ready %b, want 1", io_cmd_ready);
        end
        cyc();
        io_cmd_valid = 1'b0;
        n_checks++;
        if (io_rdata_valid !== 1'b1 || io_rdata !== a || io_rdata_last !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_rd0: vld %b data %h last %b, want 1 %h 0", io_rdata_valid, io_rdata, io_rdata_last, a);
        end
        io_rdata_ready = 1'b1;
        cyc();
        n_checks++;
        if (io_rdata_valid !== 1'b1 || io_rdata !== b || io_rdata_last !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rd1: vld %b data %h last %b, want 1 %h 1", io_rdata_valid, io_rdata, io_rdata_last, b);
        end
        cyc();
        io_rdata_ready = 1'b0;
        n_checks++;
        if (io_done !== 1'b1 || io_rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_done: done %b vld %b, want 1 0", io_done, io_rdata_valid);
        end
        cyc();
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        do_read(0, 1);
        send_cmd(1'b1, 6, 4, ok);
        io_wdata_valid = 1'b1; io_wdata = a; cyc();
        io_wdata = b; cyc();
        io_wdata_valid = 1'b0;
        mdl[6] = a;
        mdl[7] = b;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({io_cmd_ready, io_wdata_ready, io_rdata_valid, io_rdata_last, io_done, io_err} !== 6'b100000 ||
            io_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_abort: flags %b rdata %h, want 100000 0",
                     {io_cmd_ready, io_wdata_ready, io_rdata_valid, io_rdata_last, io_done, io_err}, io_rdata);
        end
        cyc();
        reset = 1'b0;
        cyc();
        do_read(6, 2);
        n_checks++;
        if (got_d[0] !== a || got_d[1] !== b || !drv_done_ok) begin
            n_fail++;
            $display("FAIL rst_retain: got %h %h done_ok %b, want %h %h 1", got_d[0], got_d[1], drv_done_ok, a, b);
        end
    endtask

    task automatic test_random();
        bit ok;
        int addr;
        int len;
        int bad;
        wgap_pct = 30;
        rstall_pct = 30;
        for (int it = 0; it < 24; it++) begin
            addr = $urandom_range(15);
            len = $urandom_range(15, 1);
            bad = 0;
`ifdef BURST_SLAVE_BOUNDARY_CHK_EN
            if (addr + len > DEPTH) begin
                send_cmd(1'b1, addr, len, ok);
                if (!ok || io_err !== 1'b1 || io_cmd_ready !== 1'b1) bad++;
                cyc();
                n_checks++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_reject a%0d l%0d: err %b, want 1", it, addr, len, io_err);
                end
                continue;
            end
`endif
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i < len; i++) wq.push_back($urandom);
                do_write(addr, len);
                n_checks++;
                if (drv_viol != 0 || !drv_done_ok) begin
                    n_fail++;
                    $display("FAIL rand%0d_wr a%0d l%0d: viol %0d done_ok %b, want 0 1", it, addr, len, drv_viol, drv_done_ok);
                end
            end else begin
                do_read(addr, len);
                for (int i = 0; i < len; i++)
                    if (got_d[i] !== mdl[(addr + i) % DEPTH] || got_l[i] !== (i == len - 1)) bad++;
                n_checks++;
                if (bad != 0 || drv_viol != 0 || !drv_done_ok || !drv_first_ok) begin
                    n_fail++;
                    $display("FAIL rand%0d_rd a%0d l%0d: %0d bad beats viol %0d done_ok %b, want 0 0 1",
                             it, addr, len, bad, drv_viol, drv_done_ok);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_backpressure();
        test_write_gaps();
        test_wrap();
        test_illegal();
        test_busy();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

endmodule
